// File: rtl/bcd_key_pkg.sv
// Shared types and constants for the BCD key-entry block: FSM states, key
// vector layout and digit helpers.
package bcd_key_pkg;

  localparam int BCD_W       = 4;
  localparam int N_KEYS      = 12;
  localparam int KEY_IDX_CLR = 10;
  localparam int KEY_IDX_ENT = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SEND = 2'd2
  } state_e;

  // Caller guarantees exactly one of the ten digit keys is set.
  function automatic logic [BCD_W-1:0] key_digit(input logic [9:0] sw);
    logic [BCD_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (sw[i]) d = BCD_W'(i);
    end
    return d;
  endfunction

  function automatic logic multi_key(input logic [N_KEYS-1:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage

// File: rtl/bcd_key_entry_if.sv
// Committed-value handshake bundle between the key-entry block and its consumer.
interface bcd_key_entry_if
  import bcd_key_pkg::*;
#(
  parameter int N_DIGITS = 4
);
  logic [BCD_W*N_DIGITS-1:0] dout;
  logic                      dout_vld;
  logic                      dout_rdy;

  modport master (output dout, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer: the held vector
// is reported stable once it has been unchanged for 2^DEB_W cycles.
module key_debounce #(
  parameter int W     = 12,
  parameter int DEB_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] p,
  output logic         stable
);

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     p_q, p_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    p_d   = p_q;
    cnt_d = cnt_q;
    if (sync2_q != p_q) begin
      p_d   = sync2_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p      = p_q;
  assign stable = (cnt_q == '1);

endmodule

// File: rtl/bcd_key_entry.sv
// Debounced keypad entry of up to N_DIGITS BCD digits, with clear, enter and a
// valid/ready handoff of the committed value.
module bcd_key_entry
  import bcd_key_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DEB_W    = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [9:0]                SW,
  input  logic                      KEY_CLR,
  input  logic                      KEY_ENT,
  output logic [BCD_W*N_DIGITS-1:0] DIGITS,
  output logic [3:0]                CNT,
  output logic [BCD_W*N_DIGITS-1:0] DOUT,
  output logic                      DOUT_VLD,
  input  logic                      DOUT_RDY,
  output logic                      ERR
);

  localparam int DW = BCD_W * N_DIGITS;

  logic [N_KEYS-1:0] raw_keys;
  logic [N_KEYS-1:0] p;
  logic              stable;

  state_e            state_q, state_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  assign raw_keys = {KEY_ENT, KEY_CLR, SW};

  key_debounce #(
    .W     (N_KEYS),
    .DEB_W (DEB_W)
  ) u_deb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .raw    (raw_keys),
    .p      (p),
    .stable (stable)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Every evaluated press leaves through S_HOLD so a held key acts once.
        if (stable && (p != '0)) begin
          state_d = S_HOLD;
          if (multi_key(p)) begin
            err_d = 1'b1;
          end else if (p[KEY_IDX_ENT]) begin
            if (cnt_q != 4'd0) begin
              dout_d   = digits_q;
              vld_d    = 1'b1;
              digits_d = '0;
              cnt_d    = '0;
              state_d  = S_SEND;
            end else begin
              err_d = 1'b1;
            end
          end else if (p[KEY_IDX_CLR]) begin
            digits_d = '0;
            cnt_d    = '0;
          end else if (cnt_q < 4'(N_DIGITS)) begin
            digits_d              = digits_q << BCD_W;
            digits_d[BCD_W-1:0]   = key_digit(p[9:0]);
            cnt_d                 = cnt_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (stable && (p == '0)) state_d = S_IDLE;
      end
      S_SEND: begin
        if (vld_q && DOUT_RDY) begin
          vld_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign DIGITS   = digits_q;
  assign CNT      = cnt_q;
  assign DOUT     = dout_q;
  assign DOUT_VLD = vld_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: directed scenarios plus random key presses checked
// against a digit-queue model of the entry buffer.
module tb_bcd_key_entry;
  import bcd_key_pkg::*;

  localparam int N     = 4;
  localparam int DEB_W = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  SW;
  logic        KEY_CLR, KEY_ENT;
  logic [15:0] DIGITS;
  logic [3:0]  CNT;
  logic        ERR;

  bcd_key_entry_if #(.N_DIGITS(N)) bus ();

  bcd_key_entry #(.N_DIGITS(N), .DEB_W(DEB_W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SW       (SW),
    .KEY_CLR  (KEY_CLR),
    .KEY_ENT  (KEY_ENT),
    .DIGITS   (DIGITS),
    .CNT      (CNT),
    .DOUT     (bus.dout),
    .DOUT_VLD (bus.dout_vld),
    .DOUT_RDY (bus.dout_rdy),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  int checks    = 0;
  int failures  = 0;
  int err_seen  = 0;
  int q[$];

  always @(negedge CLK) if (ERR === 1'b1) err_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] v;
    v = 0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  task automatic drive_keys(input logic [11:0] k);
    {KEY_ENT, KEY_CLR, SW} = k;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (bus.dout_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_settled(input int e0, input int exp_err);
    check_eq("digits", DIGITS, model_digits());
    check_eq("cnt", CNT, 32'(q.size()));
    check_eq("err_pulses", 32'(err_seen - e0), 32'(exp_err));
    check_eq("vld_idle", bus.dout_vld, 1'b0);
  endtask

  // One complete press/release, with the model deciding the outcome up front.
  task automatic press(input logic [11:0] k, input int hold, input bit early_rdy, input int rdy_dly);
    int          e0, exp_err;
    bit          enter, ok;
    logic [31:0] exp_dout;
    e0 = err_seen; exp_err = 0; enter = 0; exp_dout = 0;
    if ($countones(k) > 1) exp_err = 1;
    else if (k[11]) begin
      if (q.size() == 0) exp_err = 1;
      else begin enter = 1; exp_dout = model_digits(); q.delete(); end
    end
    else if (k[10]) q.delete();
    else if (q.size() < N) begin
      for (int i = 0; i < 10; i++) if (k[i]) q.push_back(i);
    end
    else exp_err = 1;

    if (enter) begin
      bus.dout_rdy = early_rdy;
      drive_keys(k);
      wait_vld(ok);
      check_eq("vld_rise", ok, 1'b1);
      check_eq("dout", bus.dout, exp_dout);
      check_eq("digits_after_ent", DIGITS, 0);
      check_eq("cnt_after_ent", CNT, 0);
      if (!early_rdy) begin
        @(negedge CLK);
        drive_keys('0);
        repeat (rdy_dly) @(negedge CLK);
        check_eq("vld_hold", bus.dout_vld, 1'b1);
        check_eq("dout_hold", bus.dout, exp_dout);
        bus.dout_rdy = 1'b1;
      end
      @(posedge CLK);
      #1 check_eq("vld_drop", bus.dout_vld, 1'b0);
      @(negedge CLK);
      bus.dout_rdy = 1'b0;
      drive_keys('0);
    end else begin
      drive_keys(k);
      cycles(hold);
      drive_keys('0);
    end
    cycles(12);
    check_settled(e0, exp_err);
  endtask

  function automatic logic [11:0] digit_key(input int d);
    logic [11:0] k;
    k = '0;
    k[d] = 1'b1;
    return k;
  endfunction

  // Action must land on edge 2^DEB_W+3 = 7 after the raw change.
  task automatic lat_press(input int d);
    logic [3:0] old;
    int         e0;
    e0  = err_seen;
    old = CNT;
    q.push_back(d);
    drive_keys(digit_key(d));
    repeat (6) @(posedge CLK);
    #1 check_eq("lat_not_yet", CNT, old);
    @(posedge CLK);
    #1 check_eq("lat_edge7", CNT, old + 4'd1);
    @(negedge CLK);
    cycles(3);
    drive_keys('0);
    cycles(12);
    check_settled(e0, 0);
  endtask

  task automatic glitch(input logic [11:0] k, input int len);
    int e0;
    e0 = err_seen;
    drive_keys(k);
    cycles(len);
    drive_keys('0);
    cycles(12);
    check_settled(e0, 0);
  endtask

  task automatic bounce_sw4();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 10; i++) begin
      SW[4] = ~SW[4];
      cycles(2);
    end
    SW[4] = 1'b0;
    cycles(12);
    check_settled(e0, 0);
  endtask

  task automatic reset_mid_send();
    bit ok;
    int e0;
    drive_keys(12'h800);
    bus.dout_rdy = 1'b0;
    wait_vld(ok);
    check_eq("rst_vld_up", ok, 1'b1);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    check_eq("rst_digits", DIGITS, 0);
    check_eq("rst_cnt", CNT, 0);
    check_eq("rst_dout", bus.dout, 0);
    check_eq("rst_vld", bus.dout_vld, 1'b0);
    check_eq("rst_err", ERR, 1'b0);
    q.delete();
    @(negedge CLK);
    e0 = err_seen;
    RST_N = 1'b1;
    cycles(12);
    // The still-held ENT is a fresh press with an empty buffer.
    check_eq("rst_fresh_ent_err", 32'(err_seen - e0), 1);
    drive_keys('0);
    cycles(12);
    check_settled(e0 + 1, 0);
  endtask

  initial begin
    logic [11:0] k;
    int          r, a, b, e0;
    RST_N = 1'b0;
    drive_keys('0);
    bus.dout_rdy = 1'b0;
    #2;
    check_eq("reset_digits", DIGITS, 0);
    check_eq("reset_cnt", CNT, 0);
    check_eq("reset_dout", bus.dout, 0);
    check_eq("reset_vld", bus.dout_vld, 1'b0);
    check_eq("reset_err", ERR, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    cycles(12);

    e0 = err_seen;
    lat_press(1);
    press(digit_key(2), 10, 0, 0);
    press(digit_key(3), 10, 0, 0);
    check_eq("seq123", DIGITS, 16'h0123);
    check_eq("seq123_noerr", 32'(err_seen - e0), 0);

    press(12'h800, 10, 0, 20);

    for (int i = 0; i < 5; i++) press(digit_key(9), 10, 0, 0);
    check_eq("seq9999", DIGITS, 16'h9999);

    bounce_sw4();
    press(digit_key(4) | digit_key(7), 10, 0, 0);

    press(12'h400, 10, 0, 0);
    press(12'h800, 10, 0, 0);
    press(digit_key(5), 10, 0, 0);
    press(digit_key(6), 10, 0, 0);
    press(12'h400, 10, 0, 0);

    press(digit_key(3), 10, 0, 0);
    press(12'h800, 10, 1, 0);

    press(digit_key(7), 10, 0, 0);
    reset_mid_send();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) k = digit_key($urandom_range(0, 9));
      else if (r < 65) k = 12'h400;
      else if (r < 80) k = 12'h800;
      else if (r < 90) begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        k = digit_key(a) | digit_key(b);
      end else begin
        glitch(digit_key($urandom_range(0, 11)), $urandom_range(1, 2));
        continue;
      end
      press(k, $urandom_range(8, 14), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_key_entry.md
BCD_KEY_ENTRY -- requirements
Module: bcd_key_entry

Interface
REQ-001 Parameter N_DIGITS, default 4, number of BCD digits held (legal 1..8).
REQ-002 Parameter DEB_W, default 4, debounce counter width; stable window is 2^DEB_W cycles (legal 1..20).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SW  input  10  raw digit keys 0..9, active-high, asynchronous to CLK.
REQ-006 KEY_CLR  input  1  raw clear key, active-high, asynchronous.
REQ-007 KEY_ENT  input  1  raw enter key, active-high, asynchronous.
REQ-008 DIGITS  output  4*N_DIGITS  live entry buffer; most recent digit in bits [3:0].
REQ-009 CNT  output  4  number of digits currently in DIGITS.
REQ-010 DOUT  output  4*N_DIGITS  committed value.
REQ-011 DOUT_VLD  output  1  DOUT valid.
REQ-012 DOUT_RDY  input  1  consumer accepts DOUT.
REQ-013 ERR  output  1  one-cycle error pulse.

Function
REQ-014 The 12 raw keys {KEY_ENT,KEY_CLR,SW} SHALL pass through a 2-flop synchronizer.
REQ-015 Debounce: on synchronized vector != held vector P, P loads it and counter clears; otherwise counter increments, saturating at 2^DEB_W-1; STABLE = counter at max.
REQ-016 FSM states SHALL be S_IDLE, S_HOLD, S_SEND.
REQ-017 S_IDLE: when STABLE and P != 0, evaluate P in that cycle, then go to S_HOLD (or S_SEND per REQ-021).
REQ-018 P with more than one bit set: ERR pulses, DIGITS/CNT unchanged, go to S_HOLD.
REQ-019 Single digit key k: if CNT < N_DIGITS, DIGITS <= {DIGITS[4*N_DIGITS-5:0], k}, CNT++; if CNT == N_DIGITS, ERR pulses, no change.
REQ-020 KEY_CLR alone: DIGITS <= 0, CNT <= 0, no ERR.
REQ-021 KEY_ENT alone with CNT > 0: DOUT <= DIGITS, DOUT_VLD <= 1, DIGITS <= 0, CNT <= 0, go to S_SEND; with CNT == 0: ERR pulses, go to S_HOLD.
REQ-022 S_HOLD: go to S_IDLE only when STABLE and P == 0; all key actions suppressed (no auto-repeat).
REQ-023 S_SEND: DOUT and DOUT_VLD held constant; on DOUT_VLD && DOUT_RDY, DOUT_VLD clears next edge, go to S_HOLD; keys ignored without ERR.
REQ-024 Latency: a key action SHALL update DIGITS/CNT/DOUT_VLD on the (2^DEB_W + 3)th rising edge after the raw input settles, given prior release completed.
REQ-025 Bounce shorter than 2^DEB_W cycles SHALL produce no action.
REQ-026 DOUT_RDY asserted in the same cycle DOUT_VLD rises completes the transfer on the next edge.

Reset
REQ-027 RST_N low SHALL asynchronously force: state S_IDLE, synchronizer/P/counter 0, DIGITS 0, CNT 0, DOUT 0, DOUT_VLD 0, ERR 0.
REQ-028 Reset during S_SEND SHALL drop DOUT_VLD without handshake; after release a held key is treated as a fresh press.

Structure
REQ-029 Package bcd_key_pkg SHALL hold state encoding, key indices (KEY_IDX_CLR=10, KEY_IDX_ENT=11), BCD width 4.
REQ-030 Synchronizer and debounce SHALL be sub-module key_debounce (width-parametrised vector, DEB_W), instanced once.

Verification (N_DIGITS=4, DEB_W=2)
REQ-031 Press 1, 2, 3 (each held 10 cycles, released 10) -> DIGITS=16'h0123, CNT=3, ERR never high.
REQ-032 Then press ENT, DOUT_RDY=0 for 20 cycles then 1 -> DOUT=16'h0123, DOUT_VLD high until handshake edge, DIGITS=0, CNT=0.
REQ-033 Press 9 five times -> DIGITS=16'h9999, CNT=4, single ERR pulse on fifth press.
REQ-034 SW[4] toggled every 2 cycles for 20 cycles then low -> no DIGITS change; SW[4] and SW[7] held together -> one ERR pulse, no change.
REQ-035 ENT with CNT=0 -> ERR pulse, DOUT_VLD stays 0; CLR after digits 5,6 -> DIGITS=0, CNT=0.
REQ-036 RST_N low mid-S_SEND -> all outputs 0 immediately, asynchronous to CLK.
